accelerator_top: RTL and testbench

- Binary neural network (BNN) XNOR-popcount accelerator top level.
- Host loads two on-chip SRAMs (weights, activations) through a shared write port, then pulses start.
- A PE_ROWS x PE_COLS array of XNOR-popcount PEs streams every address once and accumulates per-PE popcounts.
- An adder tree reduces the per-PE sums into total_popcount and done is raised; the bipolar dot product is 2*total_popcount - N.

---
 rtl/accelerator_top.sv | 154 +++++++++++++++
 tb/tb_accelerator_top.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/accelerator_top.sv
// BNN XNOR-popcount accelerator: two host-loaded SRAMs stream through a
// broadcast PE array whose per-PE popcount sums are reduced into total_popcount.
module accelerator_top #(
    parameter int unsigned WORD_SIZE  = 64,
    parameter int unsigned PE_ROWS    = 8,
    parameter int unsigned PE_COLS    = 8,
    parameter int unsigned SRAM_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          done,
    input  logic                          wr_en,
    input  logic [$clog2(SRAM_DEPTH)-1:0] wr_addr,
    input  logic [WORD_SIZE-1:0]          wr_data,
    input  logic                          wr_type
);
    localparam int unsigned ADDR_W = $clog2(SRAM_DEPTH);
    localparam int unsigned PC_W   = $clog2(WORD_SIZE + 1);
    localparam int unsigned ACC_W  = $clog2(SRAM_DEPTH * WORD_SIZE + 1);
    localparam int unsigned NUM_PE = PE_ROWS * PE_COLS;
    localparam int unsigned TOT_W  = 32;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SRAM_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, REDUCE, DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   k_q, k_d, rd_addr_c;
    logic                rd_en_c, start_acc_c, wr_ok_c;
    logic                rd_vld_q, pc_vld_q;
    logic                done_q, done_d;
    logic [WORD_SIZE-1:0] rd_w_q, rd_a_q;
    logic [WORD_SIZE-1:0] weight_mem_q [SRAM_DEPTH];
    logic [WORD_SIZE-1:0] act_mem_q    [SRAM_DEPTH];
    logic [PC_W-1:0]     pc_q  [NUM_PE];
    logic [PC_W-1:0]     pc_d  [NUM_PE];
    logic [ACC_W-1:0]    acc_q [NUM_PE];
    logic [ACC_W-1:0]    acc_d [NUM_PE];
    logic [TOT_W-1:0]    total_popcount, total_popcount_d, tree_sum_c;

    function automatic logic [PC_W-1:0] popcount(input logic [WORD_SIZE-1:0] x);
        logic [PC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WORD_SIZE; i++) begin
            cnt = cnt + PC_W'(x[i]);
        end
        return cnt;
    endfunction

    // Word 0 is fetched on the start edge itself so it sees pre-write SRAM data;
    // later addresses are prefetched one ahead of the RUN counter.
    always_comb begin
        state_d          = state_q;
        k_d              = k_q;
        rd_en_c          = 1'b0;
        rd_addr_c        = k_q + ADDR_W'(1);
        start_acc_c      = 1'b0;
        wr_ok_c          = 1'b0;
        done_d           = 1'b0;
        total_popcount_d = total_popcount;
        case (state_q)
            IDLE, DONE: begin
                wr_ok_c = 1'b1;
                done_d  = (state_q == DONE);
                if (start) begin
                    start_acc_c      = 1'b1;
                    state_d          = RUN;
                    k_d              = '0;
                    rd_en_c          = 1'b1;
                    rd_addr_c        = '0;
                    done_d           = 1'b0;
                    total_popcount_d = '0;
                end
            end
            RUN: begin
                rd_en_c = (k_q != LAST_ADDR);
                k_d     = k_q + ADDR_W'(1);
                if (k_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:  state_d = REDUCE;
            REDUCE: begin
                total_popcount_d = tree_sum_c;
                state_d          = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Broadcast XNOR-popcount per PE, registered before accumulation
    always_comb begin
        for (int i = 0; i < NUM_PE; i++) begin
            pc_d[i]  = popcount(~(rd_w_q ^ rd_a_q));
            acc_d[i] = acc_q[i];
            if (start_acc_c) begin
                acc_d[i] = '0;
            end else if (pc_vld_q) begin
                acc_d[i] = acc_q[i] + ACC_W'(pc_q[i]);
            end
        end
    end

    always_comb begin
        tree_sum_c = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            tree_sum_c = tree_sum_c + TOT_W'(acc_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            k_q            <= '0;
            rd_vld_q       <= 1'b0;
            pc_vld_q       <= 1'b0;
            done_q         <= 1'b0;
            total_popcount <= '0;
            for (int i = 0; i < NUM_PE; i++) begin
                pc_q[i]  <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            rd_vld_q       <= rd_en_c;
            pc_vld_q       <= rd_vld_q;
            done_q         <= done_d;
            total_popcount <= total_popcount_d;
            for (int i = 0; i < NUM_PE; i++) begin
                pc_q[i]  <= pc_d[i];
                acc_q[i] <= acc_d[i];
            end
        end
    end

    // SRAM storage and synchronous read port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok_c) begin
            if (wr_type) begin
                act_mem_q[wr_addr] <= wr_data;
            end else begin
                weight_mem_q[wr_addr] <= wr_data;
            end
        end
        if (rd_en_c) begin
            rd_w_q <= weight_mem_q[rd_addr_c];
            rd_a_q <= act_mem_q[rd_addr_c];
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_accelerator_top.sv
// Directed self-checking bench for accelerator_top: latency, popcount totals,
// write gating, done hold and mid-run reset.
module tb_accelerator_top;
    localparam int unsigned WORD_SIZE  = 64;
    localparam int unsigned SRAM_DEPTH = 64;
    localparam int unsigned ADDR_W     = 6;
    localparam longint      N_TOTAL    = 262144;

    logic                 clk = 1'b0;
    logic                 reset, start, done, wr_en, wr_type;
    logic [ADDR_W-1:0]    wr_addr;
    logic [WORD_SIZE-1:0] wr_data;

    int checks   = 0;
    int failures = 0;
    int lat;

    accelerator_top dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .done    (done),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_type (wr_type)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic typ, input int addr, input logic [WORD_SIZE-1:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_type = typ;
        wr_addr = ADDR_W'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic fill(input logic [WORD_SIZE-1:0] w, input logic [WORD_SIZE-1:0] a);
        for (int k = 0; k < SRAM_DEPTH; k++) begin
            write_word(1'b0, k, w);
            write_word(1'b1, k, a);
        end
    endtask

    // Pulse start and count rising edges until done; optionally hammer writes during RUN
    task automatic run(input bit wr_during, output int n);
        logic [WORD_SIZE-1:0] ones;
        ones = '1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (wr_during && n < 30) begin
                wr_en   = 1'b1;
                wr_type = n[0];
                wr_addr = ADDR_W'(n);
                wr_data = ones;
            end else begin
                wr_en = 1'b0;
            end
        end
        wr_en = 1'b0;
        if (!done) check("done_timeout", 0, 1);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        wr_en   = 1'b0;
        wr_type = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset with no start
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("idle_done", longint'(done), 0);
            check("idle_total", longint'(dut.total_popcount), 0);
        end

        // Demo vector: one nonzero pair, rest zero
        fill('0, '0);
        write_word(1'b0, 0, 64'h589A86C459345B3C);
        write_word(1'b1, 0, 64'h6FA49326961A604D);
        run(1'b0, lat);
        check("demo_latency", lat, 67);
        check("demo_total", longint'(dut.total_popcount), 259840);
        check("demo_dot", 2 * longint'(dut.total_popcount) - N_TOTAL, 257536);

        // Rerun without rewriting, with writes attempted during RUN
        run(1'b1, lat);
        check("rerun_latency", lat, 67);
        check("rerun_wr_ignored_total", longint'(dut.total_popcount), 259840);

        // All zeros: every XNOR bit is one
        fill('0, '0);
        run(1'b0, lat);
        check("zeros_total", longint'(dut.total_popcount), 262144);
        check("zeros_dot", 2 * longint'(dut.total_popcount) - N_TOTAL, 262144);

        // Weight ones vs act zeros: no matches anywhere
        fill('1, '0);
        run(1'b0, lat);
        check("ones_zeros_total", longint'(dut.total_popcount), 0);
        check("ones_zeros_dot", 2 * longint'(dut.total_popcount) - N_TOTAL, -262144);
        repeat (5) @(posedge clk);
        #1;
        check("done_held", longint'(done), 1);
        // Accepted start drops done one edge later
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_cleared_by_start", longint'(done), 0);
        repeat (80) @(posedge clk);
        #1;
        check("ones_zeros_rerun_total", longint'(dut.total_popcount), 0);

        // Start in same cycle as write to word 0: k=0 read sees pre-write zero
        fill('0, '0);
        @(negedge clk);
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_type = 1'b0;
        wr_addr = '0;
        wr_data = '1;
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        check("same_cycle_wr_done", longint'(done), 1);
        check("same_cycle_wr_total", longint'(dut.total_popcount), 262144);
        // Word 0 now mismatches fully: 63*64 per PE
        run(1'b0, lat);
        check("post_write_total", longint'(dut.total_popcount), 258048);

        // Reset 20 cycles into RUN aborts to IDLE
        run(1'b0, lat);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrun_reset_done", longint'(done), 0);
        check("midrun_reset_total", longint'(dut.total_popcount), 0);
        check("midrun_reset_state", longint'(dut.state_q), 0);
        repeat (70) @(posedge clk);
        #1;
        check("midrun_reset_stays_idle", longint'(done), 0);
        run(1'b0, lat);
        check("after_reset_latency", lat, 67);
        check("after_reset_total", longint'(dut.total_popcount), 258048);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
